// File: rtl/rv_branch_resolve.sv
// EX-stage branch/jump resolution: computes the real next PC, issues a registered redirect
// to IF on mispredict (held by valid/ready), pulses flush, flags misaligned targets, counts.
module rv_branch_resolve #(
  parameter int BUS_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exValid,
  input  logic             isBranch,
  input  logic             isJal,
  input  logic             isJalr,
  input  logic [BUS_W-1:0] exPc,
  input  logic [BUS_W-1:0] exImm,
  input  logic [BUS_W-1:0] rs1Val,
  input  logic             branchTaken,
  input  logic             predTaken,
  input  logic [BUS_W-1:0] predTarget,
  input  logic             redirectReady,
  output logic             redirectValid,
  output logic [BUS_W-1:0] redirectPc,
  output logic             flushReq,
  output logic             exStall,
  output logic [BUS_W-1:0] linkValue,
  output logic             misalignExc,
  output logic [BUS_W-1:0] misalignAddr,
  output logic [CNT_W-1:0] branchCount,
  output logic [CNT_W-1:0] mispredCount
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t           state_q, state_d;
  logic             is_cti, resolve, actual_taken, mispredict, misalign, do_redirect;
  logic [BUS_W-1:0] jalr_sum, target, seq_pc, next_pc;

  assign seq_pc    = exPc + {{(BUS_W-3){1'b0}}, 3'b100};
  assign linkValue = seq_pc;
  assign jalr_sum  = rs1Val + exImm;
  assign target    = isJalr ? {jalr_sum[BUS_W-1:1], 1'b0} : (exPc + exImm);

  assign redirectValid = (state_q == REDIRECT);
  assign exStall       = redirectValid & ~redirectReady;

  // A pending redirect blocks resolution even when IF is accepting it this cycle.
  assign is_cti       = isBranch | isJal | isJalr;
  assign resolve      = exValid & is_cti & ~exStall & ~redirectValid;
  assign actual_taken = isJal | isJalr | (isBranch & branchTaken);
  assign next_pc      = actual_taken ? target : seq_pc;
  assign mispredict   = (actual_taken != predTaken) |
                        (actual_taken & predTaken & (target != predTarget));
  assign misalign     = actual_taken & (target[1:0] != 2'b00);
  assign do_redirect  = resolve & mispredict & ~misalign;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (do_redirect) state_d = REDIRECT;
      REDIRECT: if (redirectReady) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      redirectPc   <= '0;
      flushReq     <= 1'b0;
      misalignExc  <= 1'b0;
      misalignAddr <= '0;
      branchCount  <= '0;
      mispredCount <= '0;
    end else begin
      state_q     <= state_d;
      flushReq    <= resolve & (mispredict | misalign);
      misalignExc <= resolve & misalign;
      if (resolve & misalign) misalignAddr <= target;
      if (do_redirect) begin
        redirectPc   <= next_pc;
        mispredCount <= mispredCount + CNT_W'(1);
      end
      if (resolve) branchCount <= branchCount + CNT_W'(1);
    end
  end

endmodule
